// File: rtl/mux_stream_pkg.sv
// Shared constants for the N:1 streaming multiplexer: arbitration modes and
// the packet-lock state encoding.
package mux_stream_pkg;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker: round-robin search starting after ptr, or
// lowest-index-wins when prio_mode is set.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      prio_mode,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx,
  output logic                      gnt_any
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0] idx_s;
  logic             hit_s;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s   = prio_mode ? SEL_W'(i) : SEL_W'((int'(ptr) + 1 + i) % NUM_CH);
      hit_s   = req[idx_s] && !gnt_any;
      gnt_idx = hit_s ? idx_s : gnt_idx;
      gnt_any = gnt_any | hit_s;
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream merger with round-robin or fixed-priority arbitration,
// packet locking on last, and a single registered output slot.
module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  state_t            state_r, state_nxt_s;
  logic [SEL_W-1:0]  rr_ptr_r, lock_ch_r;
  logic [SEL_W-1:0]  arb_idx_s, grant_s;
  logic              arb_any_s, grant_any_s;
  logic              slot_free_s, xfer_s;
  logic [DATA_W-1:0] grant_data_s;
  logic              grant_last_s;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_r),
    .prio_mode (mode == MODE_PRIO),
    .gnt_idx   (arb_idx_s),
    .gnt_any   (arb_any_s)
  );

  // Grant selection, per-channel ready and the granted channel's beat.
  always_comb begin
    slot_free_s  = !out_valid || out_ready;
    grant_s      = arb_idx_s;
    grant_any_s  = arb_any_s;
    in_ready     = '0;
    grant_data_s = '0;
    grant_last_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      grant_s     = lock_ch_r;
      grant_any_s = 1'b1;
    end else begin
      grant_s     = arb_idx_s;
      grant_any_s = arb_any_s;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i]  = !rst && slot_free_s && grant_any_s && (grant_s == SEL_W'(i));
      grant_data_s = (grant_s == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : grant_data_s;
      grant_last_s = (grant_s == SEL_W'(i)) ? in_last[i] : grant_last_s;
    end
    xfer_s = |(in_valid & in_ready);
  end

  // Packet-lock next-state: lock on a non-final beat, release on the final one.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && !grant_last_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && grant_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, arbitration pointer, lock channel and the registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= SEL_W'(NUM_CH - 1);
      lock_ch_r <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (xfer_s) begin
        lock_ch_r <= grant_s;
        if (grant_last_s) begin
          rr_ptr_r <= grant_s;
        end
      end
      if (slot_free_s) begin
        out_valid <= xfer_s;
        if (xfer_s) begin
          out_data <= grant_data_s;
          out_last <= grant_last_s;
          out_sel  <= grant_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: an abstract per-cycle model checked every
// cycle, plus literal expectations on the accepted beat sequence of each scenario.
module tb_mux_stream_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] cap_data[$];
  logic [1:0] cap_sel[$];
  logic       cap_last[$];
  int         cap_cyc[$];

  // model state
  logic       m_init = 1'b0;
  logic       m_valid, m_last, m_locked;
  logic [7:0] m_data;
  int         m_sel, m_lock_ch, m_served;

  mux_stream_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode(mode),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: evaluate the cycle at the negedge, compare, then advance to the next edge.
  always @(negedge clk) begin : model
    int         g;
    int         c;
    logic       sf;
    logic [3:0] er;
    cyc++;
    sf = !m_valid || out_ready;
    g  = -1;
    if (m_locked) begin
      g = m_lock_ch;
    end else if (mode) begin
      for (int k = 0; k < NUM_CH; k++) if (in_valid[k] && g < 0) g = k;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_served + k) % NUM_CH;
        if (in_valid[c] && g < 0) g = c;
      end
    end
    er = (!rst && sf && g >= 0) ? (4'b0001 << g) : 4'b0000;
    if (m_init) begin
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_in_ready", 32'(in_ready), 32'(er));
      if (m_valid) begin
        chk("model_out_data", 32'(out_data), 32'(m_data));
        chk("model_out_last", 32'(out_last), 32'(m_last));
        chk("model_out_sel", 32'(out_sel), 32'(m_sel));
      end
      if (out_valid && out_ready && !rst) begin
        cap_data.push_back(out_data);
        cap_sel.push_back(out_sel);
        cap_last.push_back(out_last);
        cap_cyc.push_back(cyc);
      end
    end
    if (rst) begin
      m_init   = 1'b1;
      m_valid  = 1'b0;
      m_data   = 8'h00;
      m_last   = 1'b0;
      m_sel    = 0;
      m_locked = 1'b0;
      m_lock_ch = 0;
      m_served = NUM_CH - 1;
    end else if (g >= 0 && sf && in_valid[g]) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_last  = in_last[g];
      m_sel   = g;
      if (in_last[g]) begin
        m_locked = 1'b0;
        m_served = g;
      end else begin
        m_locked  = 1'b1;
        m_lock_ch = g;
      end
    end else if (sf) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    in_valid = 4'b0000;
    run(3);
  endtask

  task automatic clear_cap();
    cap_data.delete(); cap_sel.delete(); cap_last.delete(); cap_cyc.delete();
  endtask

  task automatic set_ch(input int c, input logic [7:0] d, input logic l);
    in_data[c*8 +: 8] = d;
    in_last[c] = l;
  endtask

  task automatic chk_beat(input string name, input int k, input logic [1:0] s,
                          input logic [7:0] d, input logic l);
    if (k < cap_sel.size()) begin
      chk({name, "_sel"}, 32'(cap_sel[k]), 32'(s));
      chk({name, "_data"}, 32'(cap_data[k]), 32'(d));
      chk({name, "_last"}, 32'(cap_last[k]), 32'(l));
    end else begin
      chk({name, "_missing"}, 32'(cap_sel.size()), 32'(k + 1));
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1;
    in_valid = 4'b1111; in_last = 4'b1111;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // 1: reset with all channels requesting
    run(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    clear_cap();
    #1;
    chk("first_grant_ch0", 32'(in_ready), 32'b0001);

    // 2: round-robin single beats, back to back
    run(6);
    drain();
    chk("rr_count", 32'(cap_sel.size()), 32'd6);
    chk_beat("rr0", 0, 2'd0, 8'hA0, 1'b1);
    chk_beat("rr1", 1, 2'd1, 8'hA1, 1'b1);
    chk_beat("rr2", 2, 2'd2, 8'hA2, 1'b1);
    chk_beat("rr3", 3, 2'd3, 8'hA3, 1'b1);
    chk_beat("rr4", 4, 2'd0, 8'hA0, 1'b1);
    for (int k = 0; k + 1 < 5 && k + 1 < cap_cyc.size(); k++)
      chk("rr_throughput", 32'(cap_cyc[k+1] - cap_cyc[k]), 32'd1);

    // 3: fixed priority, ch1 starves ch3
    clear_cap();
    mode = 1'b1;
    in_valid = 4'b1010;
    run(6);
    drain();
    chk("prio_count", 32'(cap_sel.size()), 32'd6);
    for (int k = 0; k < cap_sel.size(); k++)
      chk("prio_sel", 32'(cap_sel[k]), 32'd1);

    // 4: ch2 packet locks out ch0
    clear_cap();
    mode = 1'b0;
    set_ch(0, 8'hB0, 1'b1);
    set_ch(2, 8'hC0, 1'b0);
    in_valid = 4'b0101;
    #1; chk("lock_rdy_b1", 32'(in_ready), 32'b0100);
    tick();
    set_ch(2, 8'hC1, 1'b0);
    #1; chk("lock_rdy_b2", 32'(in_ready), 32'b0100);
    tick();
    set_ch(2, 8'hC2, 1'b1);
    #1; chk("lock_rdy_b3", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0001;
    #1; chk("lock_release_ch0", 32'(in_ready), 32'b0001);
    tick();
    drain();
    chk("lock_count", 32'(cap_sel.size()), 32'd4);
    chk_beat("lock0", 0, 2'd2, 8'hC0, 1'b0);
    chk_beat("lock1", 1, 2'd2, 8'hC1, 1'b0);
    chk_beat("lock2", 2, 2'd2, 8'hC2, 1'b1);
    chk_beat("lock3", 3, 2'd0, 8'hB0, 1'b1);

    // 5: backpressure mid-packet
    clear_cap();
    set_ch(1, 8'hD0, 1'b0);
    in_valid = 4'b0010;
    tick();
    out_ready = 1'b0;
    set_ch(1, 8'hD1, 1'b0);
    #1; chk("bp_rdy_start", 32'(in_ready), 32'd0);
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'hD0);
      chk("bp_hold_sel", 32'(out_sel), 32'd1);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    set_ch(1, 8'hD2, 1'b1);
    tick();
    drain();
    chk("bp_count", 32'(cap_sel.size()), 32'd3);
    chk_beat("bp0", 0, 2'd1, 8'hD0, 1'b0);
    chk_beat("bp1", 1, 2'd1, 8'hD1, 1'b0);
    chk_beat("bp2", 2, 2'd1, 8'hD2, 1'b1);

    // 6: reset abandons a ch1 packet, ch3 then wins
    clear_cap();
    set_ch(1, 8'hE0, 1'b0);
    in_valid = 4'b0010;
    tick();
    set_ch(1, 8'hE1, 1'b0);
    tick();
    rst = 1'b1;
    set_ch(1, 8'hE2, 1'b0);
    set_ch(3, 8'hA3, 1'b1);
    in_valid = 4'b1010;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    in_valid = 4'b1000;
    #1; chk("midrst_grant_ch3", 32'(in_ready), 32'b1000);
    tick();
    drain();
    chk("midrst_count", 32'(cap_sel.size()), 32'd2);
    chk_beat("midrst0", 0, 2'd1, 8'hE0, 1'b0);
    chk_beat("midrst1", 1, 2'd3, 8'hA3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
